windowed_noise_detector: RTL and testbench

WINDOWED_NOISE_DETECTOR -- requirements
Module: windowed_noise_detector

---
 rtl/noise_det_pkg.sv | 15 +
 rtl/noise_win_counter.sv | 79 +++++++
 rtl/windowed_noise_detector.sv | 111 +++++++++++
 tb/tb_windowed_noise_detector.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/noise_det_pkg.sv
// Shared types and sizing helpers for the windowed noise detector.
// Optional build macro used by this design: NOISE_DET_ABS_EN (signed |D1| compare).
package noise_det_pkg;

  typedef enum logic {
    CLEAN = 1'b0,
    NOISY = 1'b1
  } det_state_e;

  // Bits needed for a counter that must hold values 0..maxVal (never below 1 bit).
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/noise_win_counter.sv
// Sample/crossing counter for one observation window; emits a combinational close
// pulse and verdict. NOISE_DET_ABS_EN selects the signed |D1| > Tn compare.
module noise_win_counter
  import noise_det_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int WIN_LEN  = 64,
  parameter int CROSS_TH = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] sample_i,
  input  logic [WIDTH-1:0] thresh_i,
  output logic             close_o,
  output logic             noisy_o
);

  localparam int SW = cntWidth(WIN_LEN - 1);
  localparam int CW = cntWidth(CROSS_TH);

  logic [SW-1:0] sampleCnt_q, sampleCnt_d;
  logic [CW-1:0] crossCnt_q, crossCnt_d;
  logic [CW:0]   crossSum;
  logic          crossHit;
  logic          lastSample;
  logic          thReached;

`ifdef NOISE_DET_ABS_EN
  logic [WIDTH-1:0] sampleMag;

  // The most-negative code has no positive twin, so it clamps to the largest positive value.
  always_comb begin
    sampleMag = sample_i;
    if (sample_i[WIDTH-1]) begin
      if (sample_i == {1'b1, {(WIDTH-1){1'b0}}}) begin
        sampleMag = {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        sampleMag = (~sample_i) + 1'b1;
      end
    end
    crossHit = (sampleMag > thresh_i);
  end
`else
  always_comb begin
    crossHit = (sample_i > thresh_i);
  end
`endif

  always_comb begin
    lastSample  = (sampleCnt_q == SW'(WIN_LEN - 1));
    crossSum    = {1'b0, crossCnt_q} + (CW + 1)'(crossHit);
    thReached   = (crossSum >= (CW + 1)'(CROSS_TH));
    close_o     = valid_i && lastSample;
    noisy_o     = thReached;
    sampleCnt_d = sampleCnt_q;
    crossCnt_d  = crossCnt_q;
    if (valid_i) begin
      if (lastSample) begin
        sampleCnt_d = '0;
        crossCnt_d  = '0;
      end else begin
        sampleCnt_d = sampleCnt_q + 1'b1;
        crossCnt_d  = thReached ? CW'(CROSS_TH) : crossSum[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sampleCnt_q <= '0;
      crossCnt_q  <= '0;
    end else begin
      sampleCnt_q <= sampleCnt_d;
      crossCnt_q  <= crossCnt_d;
    end
  end

endmodule

// File: rtl/windowed_noise_detector.sv
// Window-based noise detector with hysteresis between CLEAN and NOISY states.
// Build macro NOISE_DET_ABS_EN treats D1 as two's-complement and compares |D1|.
module windowed_noise_detector
  import noise_det_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int WIN_LEN     = 64,
  parameter int CROSS_TH    = 3,
  parameter int ASSERT_WIN  = 9,
  parameter int RELEASE_WIN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] Tn,
  output logic             Select,
  output logic             win_done,
  output logic             win_noisy
);

  localparam int RUN_MAX = (ASSERT_WIN > RELEASE_WIN) ? ASSERT_WIN : RELEASE_WIN;
  localparam int RW      = cntWidth(RUN_MAX);

  if (WIN_LEN < 2) begin : gBadWinLen
    $error("windowed_noise_detector: WIN_LEN must be >= 2");
  end
  if ((CROSS_TH < 1) || (CROSS_TH > WIN_LEN)) begin : gBadCrossTh
    $error("windowed_noise_detector: CROSS_TH must be in 1..WIN_LEN");
  end
  if ((ASSERT_WIN < 1) || (RELEASE_WIN < 1)) begin : gBadRunLen
    $error("windowed_noise_detector: ASSERT_WIN and RELEASE_WIN must be >= 1");
  end

  logic          closeHit;
  logic          verdict;
  det_state_e    state_q, state_d;
  logic [RW-1:0] run_q, run_d, runInc;
  logic          winDone_q, winDone_d;
  logic          winNoisy_q, winNoisy_d;

  noise_win_counter #(
    .WIDTH   (WIDTH),
    .WIN_LEN (WIN_LEN),
    .CROSS_TH(CROSS_TH)
  ) uWinCounter (
    .clk_i   (clk),
    .reset_i (reset),
    .valid_i (d_valid),
    .sample_i(D1),
    .thresh_i(Tn),
    .close_o (closeHit),
    .noisy_o (verdict)
  );

  // The run counter tracks consecutive windows that disagree with the current state.
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    runInc     = run_q + 1'b1;
    winDone_d  = closeHit;
    winNoisy_d = closeHit && verdict;
    if (closeHit) begin
      case (state_q)
        CLEAN: begin
          if (!verdict) begin
            run_d = '0;
          end else if (runInc == RW'(ASSERT_WIN)) begin
            state_d = NOISY;
            run_d   = '0;
          end else begin
            run_d = runInc;
          end
        end
        NOISY: begin
          if (verdict) begin
            run_d = '0;
          end else if (runInc == RW'(RELEASE_WIN)) begin
            state_d = CLEAN;
            run_d   = '0;
          end else begin
            run_d = runInc;
          end
        end
        default: begin
          state_d = CLEAN;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAN;
      run_q      <= '0;
      winDone_q  <= 1'b0;
      winNoisy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      winDone_q  <= winDone_d;
      winNoisy_q <= winNoisy_d;
    end
  end

  assign Select    = (state_q == NOISY);
  assign win_done  = winDone_q;
  assign win_noisy = winNoisy_q;

endmodule

// File: tb/tb_windowed_noise_detector.sv
// Directed, scoreboard-based bench for windowed_noise_detector (default parameters).
// Define NOISE_DET_ABS_EN for both RTL and bench to exercise the signed-magnitude build.
module tb_windowed_noise_detector;

  localparam int WIDTH       = 16;
  localparam int WIN_LEN     = 64;
  localparam int CROSS_TH    = 3;
  localparam int ASSERT_WIN  = 9;
  localparam int RELEASE_WIN = 4;

  typedef struct packed {
    logic noisy;
    logic sel;
  } expect_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             d_valid;
  logic [WIDTH-1:0] D1;
  logic [WIDTH-1:0] Tn;
  logic             Select;
  logic             win_done;
  logic             win_noisy;

  expect_t expQ[$];
  int      checks = 0;
  int      errors = 0;
  int      mSample;
  int      mCross;
  int      mRun;
  logic    mSel;

  windowed_noise_detector #(
    .WIDTH      (WIDTH),
    .WIN_LEN    (WIN_LEN),
    .CROSS_TH   (CROSS_TH),
    .ASSERT_WIN (ASSERT_WIN),
    .RELEASE_WIN(RELEASE_WIN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .d_valid  (d_valid),
    .D1       (D1),
    .Tn       (Tn),
    .Select   (Select),
    .win_done (win_done),
    .win_noisy(win_noisy)
  );

  always #5 clk = ~clk;

  function automatic logic modelCross(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] t);
`ifdef NOISE_DET_ABS_EN
    int s;
    s = int'($signed(d));
    if (s < 0) s = -s;
    if (s > 32767) s = 32767;
    return (s > int'(t));
`else
    return (int'(d) > int'(t));
`endif
  endfunction

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference model: unsaturated crossing count, window verdict, hysteresis.
  task automatic modelStep(input logic [WIDTH-1:0] d);
    logic noisy;
    expect_t e;
    mCross += modelCross(d, Tn) ? 1 : 0;
    if (mSample == WIN_LEN - 1) begin
      noisy = (mCross >= CROSS_TH);
      if (mSel == 1'b0) begin
        mRun = noisy ? mRun + 1 : 0;
        if (mRun == ASSERT_WIN) begin
          mSel = 1'b1;
          mRun = 0;
        end
      end else begin
        mRun = noisy ? 0 : mRun + 1;
        if (mRun == RELEASE_WIN) begin
          mSel = 1'b0;
          mRun = 0;
        end
      end
      e.noisy = noisy;
      e.sel   = mSel;
      expQ.push_back(e);
      mSample = 0;
      mCross  = 0;
    end else begin
      mSample++;
    end
  endtask

  task automatic checkOutput(input logic wasReset);
    expect_t e;
    if (wasReset) begin
      checkBit("reset win_noisy", win_noisy, 1'b0);
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkBit("win_done at close", win_done, 1'b1);
      checkBit("win_noisy at close", win_noisy, e.noisy);
      checkBit("Select at close", Select, e.sel);
    end else begin
      checkBit("win_done idle", win_done, 1'b0);
      checkBit("Select steady", Select, mSel);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic v, input logic [WIDTH-1:0] d);
    reset   = rst;
    d_valid = v;
    D1      = d;
    if (rst) begin
      mSample = 0;
      mCross  = 0;
      mRun    = 0;
      mSel    = 1'b0;
      expQ.delete();
    end else if (v) begin
      modelStep(d);
    end
    @(posedge clk);
    #1;
    checkOutput(rst);
  endtask

  // Loud samples go at positions firstPos..firstPos+nCross-1; gapped inserts ignored idle cycles.
  task automatic driveWindow(input int nCross, input int firstPos,
                             input logic [WIDTH-1:0] quiet, input bit gapped);
    for (int i = 0; i < WIN_LEN; i++) begin
      applyStimulus(1'b0, 1'b1, (i >= firstPos && i < firstPos + nCross) ? 16'd200 : quiet);
      if (gapped) applyStimulus(1'b0, 1'b0, 16'd200);
    end
  endtask

  initial begin
    reset   = 1'b1;
    d_valid = 1'b0;
    D1      = '0;
    Tn      = 16'd100;
    mSample = 0;
    mCross  = 0;
    mRun    = 0;
    mSel    = 1'b0;
    @(negedge clk);

    // Reset overrides a valid loud sample.
    applyStimulus(1'b1, 1'b1, 16'd200);
    applyStimulus(1'b1, 1'b1, 16'd200);
    checkBit("reset Select", Select, 1'b0);

    // Nine noisy windows; the last one finishes its crossings on the closing sample.
    repeat (8) driveWindow(3, 10, 16'd5, 1'b0);
    checkBit("Select before 9th window", Select, 1'b0);
    driveWindow(3, 61, 16'd5, 1'b0);
    checkBit("Select after 9th window", Select, 1'b1);

    // Three clean then one noisy keeps NOISY; four clean in a row releases.
    repeat (3) driveWindow(0, 0, 16'd0, 1'b0);
    driveWindow(3, 0, 16'd5, 1'b0);
    checkBit("Select held after interrupted release", Select, 1'b1);
    repeat (3) driveWindow(0, 0, 16'd0, 1'b0);
    checkBit("Select before 4th clean window", Select, 1'b1);
    driveWindow(0, 0, 16'd0, 1'b0);
    checkBit("Select after 4th clean window", Select, 1'b0);

    // A two-crossing window breaks the noisy run.
    repeat (8) driveWindow(3, 20, 16'd5, 1'b0);
    driveWindow(2, 20, 16'd5, 1'b0);
    repeat (8) driveWindow(3, 20, 16'd5, 1'b0);
    checkBit("Select after 16 noisy total", Select, 1'b0);
    driveWindow(3, 20, 16'd5, 1'b0);
    checkBit("Select after 17th noisy total", Select, 1'b1);
    repeat (4) driveWindow(0, 0, 16'd0, 1'b0);
    checkBit("Select released again", Select, 1'b0);

    // Valid toggling every cycle; D1 equal to Tn is not a crossing.
    driveWindow(0, 0, 16'd100, 1'b1);
    checkBit("win_done after gap cycle", win_done, 1'b0);

    // Reset mid-window discards 40 samples holding two crossings.
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, (i < 2) ? 16'd200 : 16'd5);
    applyStimulus(1'b1, 1'b1, 16'd200);
    driveWindow(1, 63, 16'd5, 1'b0);

`ifdef NOISE_DET_ABS_EN
    // Negative and most-negative samples count via their magnitude.
    for (int i = 0; i < WIN_LEN; i++) begin
      applyStimulus(1'b0, 1'b1, (i == 5 || i == 7) ? 16'hFF38 : (i == 6) ? 16'h8000 : 16'h0000);
    end
    checkBit("abs window done", win_done, 1'b1);
    checkBit("abs window noisy", win_noisy, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
